// File: rtl/frame_buf_pkg.sv
// Shared definitions for the ping-pong frame buffer controller: bank indexing
// and the active-low RAM enable encoding.
package frame_buf_pkg;
    localparam int DATA_WIDTH_DEF = 32;
    localparam int NUM_BANKS      = 2;

    typedef logic [$clog2(NUM_BANKS)-1:0] bank_t;

    localparam logic EN_ASSERT   = 1'b0;
    localparam logic EN_DEASSERT = 1'b1;
endpackage

// File: rtl/frame_buf_bank_ptr.sv
// Word pointer plus bank select for one side of the ping-pong buffer; wraps at
// FRAME_SIZE and moves to the next bank on the wrapping advance.
module frame_buf_bank_ptr
    import frame_buf_pkg::*;
#(
    parameter int FRAME_AW   = 4,
    parameter int FRAME_SIZE = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                advance,
    output logic [FRAME_AW-1:0] ptr,
    output bank_t               bank,
    output logic                wrap
);
    localparam logic [FRAME_AW-1:0] LAST = FRAME_AW'(FRAME_SIZE - 1);

    // Combinational so the top can update bank flags on the same edge.
    assign wrap = advance && (ptr == LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr  <= '0;
            bank <= '0;
        end else if (advance) begin
            if (wrap) begin
                ptr  <= '0;
                bank <= bank + 1'b1;
            end else begin
                ptr <= ptr + 1'b1;
            end
        end
    end
endmodule

// File: rtl/frame_buf_ctrl.sv
// Two-bank ping-pong frame buffer controller: the writer fills one bank while
// the reader drains the other, with per-bank full flags arbitrating ownership.
module frame_buf_ctrl
    import frame_buf_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int FRAME_AW   = 4,
    parameter int FRAME_SIZE = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_req,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_ready,
    input  logic                  rd_req,
    output logic                  rd_avail,
    output logic                  rd_valid,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  buf_wr_en_n,
    output logic [FRAME_AW:0]     buf_wr_addr,
    output logic [DATA_WIDTH-1:0] buf_data_in,
    output logic                  buf_rd_en_n,
    output logic [FRAME_AW:0]     buf_rd_addr,
    input  logic [DATA_WIDTH-1:0] buf_data_out,
    output logic                  frame_wr_done,
    output logic                  frame_rd_done,
    output logic [15:0]           frame_cnt
);
    logic [NUM_BANKS-1:0] full;
    logic [FRAME_AW-1:0]  wr_ptr;
    logic [FRAME_AW-1:0]  rd_ptr;
    bank_t                wr_bank;
    bank_t                rd_bank;
    logic                 wr_wrap;
    logic                 rd_wrap;
    logic                 wr_accept;
    logic                 rd_issue;

    assign wr_ready  = ~full[wr_bank];
    assign rd_avail  = full[rd_bank];
    assign wr_accept = wr_req && wr_ready;
    assign rd_issue  = rd_req && rd_avail;

    assign buf_wr_en_n = wr_accept ? EN_ASSERT : EN_DEASSERT;
    assign buf_rd_en_n = rd_issue ? EN_ASSERT : EN_DEASSERT;
    assign buf_wr_addr = {wr_bank, wr_ptr};
    assign buf_rd_addr = {rd_bank, rd_ptr};
    assign buf_data_in = wr_data;

    // The RAM already adds the read register stage, so the word is forwarded
    // in the cycle after issue and forced to zero otherwise.
    assign rd_data = rd_valid ? buf_data_out : '0;

    frame_buf_bank_ptr #(
        .FRAME_AW   (FRAME_AW),
        .FRAME_SIZE (FRAME_SIZE)
    ) u_wr_ptr (
        .clk     (clk),
        .reset   (reset),
        .advance (wr_accept),
        .ptr     (wr_ptr),
        .bank    (wr_bank),
        .wrap    (wr_wrap)
    );

    frame_buf_bank_ptr #(
        .FRAME_AW   (FRAME_AW),
        .FRAME_SIZE (FRAME_SIZE)
    ) u_rd_ptr (
        .clk     (clk),
        .reset   (reset),
        .advance (rd_issue),
        .ptr     (rd_ptr),
        .bank    (rd_bank),
        .wrap    (rd_wrap)
    );

    // Fill and drain always target different banks, so set and clear never collide.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            full <= '0;
        end else begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                if (wr_wrap && (wr_bank == bank_t'(b))) begin
                    full[b] <= 1'b1;
                end else if (rd_wrap && (rd_bank == bank_t'(b))) begin
                    full[b] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_valid      <= 1'b0;
            frame_wr_done <= 1'b0;
            frame_rd_done <= 1'b0;
            frame_cnt     <= '0;
        end else begin
            rd_valid      <= rd_issue;
            frame_wr_done <= wr_wrap;
            frame_rd_done <= rd_wrap;
            if (wr_wrap) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_frame_buf_ctrl.sv
// Self-checking bench for frame_buf_ctrl with a behavioural RAM and a
// frame-level reference model driven by random traffic.
module tb_frame_buf_ctrl;
    localparam int DW = 32;
    localparam int AW = 2;
    localparam int FS = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          wr_req;
    logic [DW-1:0] wr_data;
    logic          wr_ready;
    logic          rd_req;
    logic          rd_avail;
    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic          buf_wr_en_n;
    logic [AW:0]   buf_wr_addr;
    logic [DW-1:0] buf_data_in;
    logic          buf_rd_en_n;
    logic [AW:0]   buf_rd_addr;
    logic [DW-1:0] buf_data_out = '0;
    logic          frame_wr_done;
    logic          frame_rd_done;
    logic [15:0]   frame_cnt;

    logic [DW-1:0] mem [0:2*FS-1];

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    frame_buf_ctrl #(.DATA_WIDTH(DW), .FRAME_AW(AW), .FRAME_SIZE(FS)) dut (
        .clk           (clk),
        .reset         (reset),
        .wr_req        (wr_req),
        .wr_data       (wr_data),
        .wr_ready      (wr_ready),
        .rd_req        (rd_req),
        .rd_avail      (rd_avail),
        .rd_valid      (rd_valid),
        .rd_data       (rd_data),
        .buf_wr_en_n   (buf_wr_en_n),
        .buf_wr_addr   (buf_wr_addr),
        .buf_data_in   (buf_data_in),
        .buf_rd_en_n   (buf_rd_en_n),
        .buf_rd_addr   (buf_rd_addr),
        .buf_data_out  (buf_data_out),
        .frame_wr_done (frame_wr_done),
        .frame_rd_done (frame_rd_done),
        .frame_cnt     (frame_cnt)
    );

    // Buffer RAM: write captured at the edge, registered read data.
    always @(posedge clk) begin
        if (!buf_wr_en_n) mem[buf_wr_addr] <= buf_data_in;
        if (!buf_rd_en_n) buf_data_out <= mem[buf_rd_addr];
    end

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b0; wr_req = 1'b0; rd_req = 1'b0; wr_data = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        #1;
        total_cnt++; if (wr_ready !== 1'b1) $display("FAIL reset_wr_ready got=%b exp=1", wr_ready); else pass_cnt++;
        total_cnt++; if (rd_avail !== 1'b0) $display("FAIL reset_rd_avail got=%b exp=0", rd_avail); else pass_cnt++;
        total_cnt++; if (buf_wr_en_n !== 1'b1) $display("FAIL reset_wr_en_n got=%b exp=1", buf_wr_en_n); else pass_cnt++;
        total_cnt++; if (buf_rd_en_n !== 1'b1) $display("FAIL reset_rd_en_n got=%b exp=1", buf_rd_en_n); else pass_cnt++;
        total_cnt++; if (frame_cnt !== 16'd0) $display("FAIL reset_frame_cnt got=%0d exp=0", frame_cnt); else pass_cnt++;
        total_cnt++; if (rd_valid !== 1'b0) $display("FAIL reset_rd_valid got=%b exp=0", rd_valid); else pass_cnt++;
    endtask

    task automatic test_first_frame();
        for (int i = 0; i < FS; i++) begin
            @(negedge clk);
            wr_req = 1'b1; wr_data = DW'(i + 1);
            #1;
            total_cnt++; if (buf_wr_addr !== 3'(i)) $display("FAIL first_wr_addr got=%0d exp=%0d", buf_wr_addr, i); else pass_cnt++;
            total_cnt++; if (buf_wr_en_n !== 1'b0) $display("FAIL first_wr_en_n got=%b exp=0", buf_wr_en_n); else pass_cnt++;
            total_cnt++; if (frame_wr_done !== 1'b0) $display("FAIL first_done_early got=%b exp=0", frame_wr_done); else pass_cnt++;
        end
        @(negedge clk);
        wr_req = 1'b0;
        #1;
        total_cnt++; if (frame_wr_done !== 1'b1) $display("FAIL first_wr_done got=%b exp=1", frame_wr_done); else pass_cnt++;
        total_cnt++; if (rd_avail !== 1'b1) $display("FAIL first_rd_avail got=%b exp=1", rd_avail); else pass_cnt++;
        total_cnt++; if (frame_cnt !== 16'd1) $display("FAIL first_frame_cnt got=%0d exp=1", frame_cnt); else pass_cnt++;
    endtask

    task automatic test_drain();
        for (int i = 0; i < FS; i++) begin
            @(negedge clk);
            rd_req = 1'b1;
            #1;
            total_cnt++; if (buf_rd_addr !== 3'(i)) $display("FAIL drain_rd_addr got=%0d exp=%0d", buf_rd_addr, i); else pass_cnt++;
            total_cnt++; if (buf_rd_en_n !== 1'b0) $display("FAIL drain_rd_en_n got=%b exp=0", buf_rd_en_n); else pass_cnt++;
            if (i == 0) begin
                total_cnt++; if (frame_wr_done !== 1'b0) $display("FAIL drain_wr_done_once got=%b exp=0", frame_wr_done); else pass_cnt++;
            end else begin
                total_cnt++; if (rd_valid !== 1'b1) $display("FAIL drain_rd_valid got=%b exp=1", rd_valid); else pass_cnt++;
                total_cnt++; if (rd_data !== DW'(i)) $display("FAIL drain_rd_data got=%0h exp=%0h", rd_data, i); else pass_cnt++;
            end
        end
        @(negedge clk);
        rd_req = 1'b0;
        #1;
        total_cnt++; if (rd_data !== DW'(4)) $display("FAIL drain_last_data got=%0h exp=4", rd_data); else pass_cnt++;
        total_cnt++; if (frame_rd_done !== 1'b1) $display("FAIL drain_rd_done got=%b exp=1", frame_rd_done); else pass_cnt++;
        total_cnt++; if (rd_avail !== 1'b0) $display("FAIL drain_rd_avail got=%b exp=0", rd_avail); else pass_cnt++;
        @(negedge clk);
        #1;
        total_cnt++; if (frame_rd_done !== 1'b0) $display("FAIL drain_rd_done_once got=%b exp=0", frame_rd_done); else pass_cnt++;
        total_cnt++; if (rd_valid !== 1'b0) $display("FAIL drain_valid_drop got=%b exp=0", rd_valid); else pass_cnt++;
    endtask

    task automatic test_both_full();
        apply_reset();
        for (int i = 0; i < 2 * FS; i++) begin
            @(negedge clk);
            wr_req = 1'b1; wr_data = DW'(32'h10 + i);
            #1;
            total_cnt++; if (buf_wr_addr !== 3'(i)) $display("FAIL full_wr_addr got=%0d exp=%0d", buf_wr_addr, i); else pass_cnt++;
        end
        for (int i = 0; i < FS; i++) begin
            @(negedge clk);
            wr_req = 1'b1; wr_data = 32'h99; rd_req = 1'b1;
            #1;
            total_cnt++; if (wr_ready !== 1'b0) $display("FAIL full_stall got=%b exp=0", wr_ready); else pass_cnt++;
            total_cnt++; if (buf_wr_en_n !== 1'b1) $display("FAIL full_no_write got=%b exp=1", buf_wr_en_n); else pass_cnt++;
            total_cnt++; if (buf_rd_addr !== 3'(i)) $display("FAIL full_rd_addr got=%0d exp=%0d", buf_rd_addr, i); else pass_cnt++;
        end
        @(negedge clk);
        rd_req = 1'b0;
        #1;
        total_cnt++; if (wr_ready !== 1'b1) $display("FAIL full_ready_rise got=%b exp=1", wr_ready); else pass_cnt++;
        total_cnt++; if (buf_wr_addr !== 3'd0) $display("FAIL full_9th_addr got=%0d exp=0", buf_wr_addr); else pass_cnt++;
        total_cnt++; if (rd_data !== 32'h13) $display("FAIL full_last_rd got=%0h exp=13", rd_data); else pass_cnt++;
        @(posedge clk);
        #1;
        total_cnt++; if (mem[0] !== 32'h99) $display("FAIL full_9th_landed got=%0h exp=99", mem[0]); else pass_cnt++;
        @(negedge clk);
        wr_req = 1'b0;
    endtask

    task automatic test_simultaneous();
        apply_reset();
        for (int i = 0; i < 2 * FS; i++) begin
            @(negedge clk);
            wr_req = 1'b1; wr_data = DW'(i); rd_req = (i >= FS);
            #1;
            if (i == 2 * FS - 1) begin
                total_cnt++; if (buf_wr_addr !== 3'd7 || buf_wr_en_n !== 1'b0) $display("FAIL simul_wr addr=%0d en_n=%b exp=7/0", buf_wr_addr, buf_wr_en_n); else pass_cnt++;
                total_cnt++; if (buf_rd_addr !== 3'd3 || buf_rd_en_n !== 1'b0) $display("FAIL simul_rd addr=%0d en_n=%b exp=3/0", buf_rd_addr, buf_rd_en_n); else pass_cnt++;
            end
        end
        @(negedge clk);
        wr_req = 1'b0; rd_req = 1'b0;
        #1;
        total_cnt++; if (dut.full !== 2'b10) $display("FAIL simul_full got=%b exp=10", dut.full); else pass_cnt++;
        total_cnt++; if (frame_wr_done !== 1'b1 || frame_rd_done !== 1'b1) $display("FAIL simul_done got=%b%b exp=11", frame_wr_done, frame_rd_done); else pass_cnt++;
        total_cnt++; if (rd_avail !== 1'b1 || wr_ready !== 1'b1) $display("FAIL simul_flags avail=%b ready=%b exp=1/1", rd_avail, wr_ready); else pass_cnt++;
        total_cnt++; if (frame_cnt !== 16'd2) $display("FAIL simul_frame_cnt got=%0d exp=2", frame_cnt); else pass_cnt++;
    endtask

    task automatic test_reset_mid_frame();
        apply_reset();
        for (int i = 0; i < FS + 2; i++) begin
            @(negedge clk);
            wr_req = 1'b1; wr_data = DW'(32'hA0 + i);
        end
        @(negedge clk);
        wr_req = 1'b0; reset = 1'b0;
        #1;
        total_cnt++; if (dut.full !== 2'b00) $display("FAIL rstmid_full got=%b exp=00", dut.full); else pass_cnt++;
        total_cnt++; if (buf_wr_addr !== 3'd0) $display("FAIL rstmid_wr_addr got=%0d exp=0", buf_wr_addr); else pass_cnt++;
        total_cnt++; if (rd_avail !== 1'b0) $display("FAIL rstmid_rd_avail got=%b exp=0", rd_avail); else pass_cnt++;
        total_cnt++; if (frame_cnt !== 16'd0) $display("FAIL rstmid_frame_cnt got=%0d exp=0", frame_cnt); else pass_cnt++;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        wr_req = 1'b1; wr_data = 32'h55;
        #1;
        total_cnt++; if (buf_wr_addr !== 3'd0 || buf_wr_en_n !== 1'b0) $display("FAIL rstmid_next addr=%0d en_n=%b exp=0/0", buf_wr_addr, buf_wr_en_n); else pass_cnt++;
        @(negedge clk);
        wr_req = 1'b0;
    endtask

    // Reference model: frames completed by each side, word offsets, and a FIFO of words.
    task automatic test_random();
        int unsigned fw = 0, fr = 0, wp = 0, rp = 0;
        bit wd_exp = 0, rdn_exp = 0, vld_exp = 0;
        bit exp_ready, exp_avail, acc, iss;
        logic [DW-1:0] dat_exp = '0;
        logic [DW-1:0] q[$];
        apply_reset();
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            wr_req = ($urandom_range(0, 9) < 7);
            wr_data = $urandom;
            rd_req = ($urandom_range(0, 9) < 4);
            #1;
            exp_ready = (fw - fr) < 2;
            exp_avail = (fw - fr) > 0;
            acc = wr_req && exp_ready;
            iss = rd_req && exp_avail;
            total_cnt++; if (wr_ready !== exp_ready) $display("FAIL rand_wr_ready c=%0d got=%b exp=%b", c, wr_ready, exp_ready); else pass_cnt++;
            total_cnt++; if (rd_avail !== exp_avail) $display("FAIL rand_rd_avail c=%0d got=%b exp=%b", c, rd_avail, exp_avail); else pass_cnt++;
            total_cnt++; if (buf_wr_en_n !== !acc) $display("FAIL rand_wr_en_n c=%0d got=%b exp=%b", c, buf_wr_en_n, !acc); else pass_cnt++;
            total_cnt++; if (buf_rd_en_n !== !iss) $display("FAIL rand_rd_en_n c=%0d got=%b exp=%b", c, buf_rd_en_n, !iss); else pass_cnt++;
            if (acc) begin
                total_cnt++; if (buf_wr_addr !== 3'((fw % 2) * FS + wp)) $display("FAIL rand_wr_addr c=%0d got=%0d exp=%0d", c, buf_wr_addr, (fw % 2) * FS + wp); else pass_cnt++;
            end
            if (iss) begin
                total_cnt++; if (buf_rd_addr !== 3'((fr % 2) * FS + rp)) $display("FAIL rand_rd_addr c=%0d got=%0d exp=%0d", c, buf_rd_addr, (fr % 2) * FS + rp); else pass_cnt++;
            end
            total_cnt++; if (rd_valid !== vld_exp) $display("FAIL rand_rd_valid c=%0d got=%b exp=%b", c, rd_valid, vld_exp); else pass_cnt++;
            if (vld_exp) begin
                total_cnt++; if (rd_data !== dat_exp) $display("FAIL rand_rd_data c=%0d got=%0h exp=%0h", c, rd_data, dat_exp); else pass_cnt++;
            end
            total_cnt++; if (frame_wr_done !== wd_exp || frame_rd_done !== rdn_exp) $display("FAIL rand_done c=%0d got=%b%b exp=%b%b", c, frame_wr_done, frame_rd_done, wd_exp, rdn_exp); else pass_cnt++;
            total_cnt++; if (frame_cnt !== 16'(fw)) $display("FAIL rand_frame_cnt c=%0d got=%0d exp=%0d", c, frame_cnt, fw); else pass_cnt++;
            wd_exp = 0; rdn_exp = 0; vld_exp = iss;
            if (acc) begin
                q.push_back(wr_data);
                wp++;
                if (wp == FS) begin wp = 0; fw++; wd_exp = 1; end
            end
            if (iss) begin
                dat_exp = q.pop_front();
                rp++;
                if (rp == FS) begin rp = 0; fr++; rdn_exp = 1; end
            end
        end
        @(negedge clk);
        wr_req = 1'b0; rd_req = 1'b0;
    endtask

    initial begin
        reset = 1'b0; wr_req = 1'b0; rd_req = 1'b0; wr_data = '0;
        test_reset();
        test_first_frame();
        test_drain();
        test_both_full();
        test_simultaneous();
        test_reset_mid_frame();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
